// File: rtl/mac_operand_loader_if.sv
// ---------------------------------------------------------------------------
// mac_operand_loader_if
// Bundles the streaming input handshake and the committed-vector consumer
// handshake of the MAC operand loader into one interface.
//
// Signals:
//   in_data   [DW-1:0]    streamed operand sample
//   in_valid              in_data is valid this cycle
//   in_last               marks the final sample of a frame
//   in_ready              loader accepts a sample this cycle
//   a_vec     [N*DW-1:0]  committed A vector, element i at [i*DW +: DW]
//   b_vec     [N*DW-1:0]  committed B vector, same packing as a_vec
//   vec_valid             a committed frame is held for the consumer
//   vec_ack               consumer has taken the held frame
//   frame_err             one-cycle pulse when a malformed frame is dropped
//   frame_cnt [7:0]       count of acknowledged frames
//
// Modports:
//   slave  - the loader itself
//   master - the producer/consumer environment driving the loader
// ---------------------------------------------------------------------------
interface mac_operand_loader_if #(
   parameter int DW = 4,
   parameter int N  = 4
);

   logic [DW-1:0]   in_data;
   logic            in_valid;
   logic            in_last;
   logic            in_ready;
   logic [N*DW-1:0] a_vec;
   logic [N*DW-1:0] b_vec;
   logic            vec_valid;
   logic            vec_ack;
   logic            frame_err;
   logic [7:0]      frame_cnt;

   modport slave (
      input  in_data, in_valid, in_last, vec_ack,
      output in_ready, a_vec, b_vec, vec_valid, frame_err, frame_cnt
   );

   modport master (
      output in_data, in_valid, in_last, vec_ack,
      input  in_ready, a_vec, b_vec, vec_valid, frame_err, frame_cnt
   );

endinterface

// File: rtl/mac_operand_loader.sv
// ---------------------------------------------------------------------------
// mac_operand_loader
// Collects a frame of 2N streamed samples into an A vector (first N beats)
// and a B vector (last N beats), then presents both to a MAC consumer until
// it acknowledges them. Frames whose in_last marker is misplaced are
// discarded with a one-cycle frame_err pulse.
//
// Ports:
//   cp      clock, all state updates on the rising edge
//   rst     asynchronous active-high reset
//   io_bus  mac_operand_loader_if.slave carrying the sample stream,
//           committed vectors, consumer handshake, error pulse and the
//           acknowledged-frame counter
// ---------------------------------------------------------------------------
module mac_operand_loader #(
   parameter int DW = 4,
   parameter int N  = 4
) (
   input  logic                 cp,
   input  logic                 rst,
   mac_operand_loader_if.slave  io_bus
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      LOAD_A,
      LOAD_B,
      HOLD
   } state_t;

   state_t          r_state;
   state_t          w_nextState;
   logic [IW-1:0]   r_idx;
   logic [IW-1:0]   w_nextIdx;
   logic [N*DW-1:0] r_stageA;
   logic [N*DW-1:0] r_stageB;
   logic [N*DW-1:0] r_aVec;
   logic [N*DW-1:0] r_bVec;
   logic [N*DW-1:0] w_stageBMerged;
   logic            r_frameErr;
   logic [7:0]      r_frameCnt;

   logic            w_beat;
   logic            w_lastElem;
   logic            w_wrA;
   logic            w_wrB;
   logic            w_commit;
   logic            w_err;
   logic            w_ackTaken;

   assign w_beat     = io_bus.in_valid && (r_state != HOLD);
   assign w_lastElem = (r_idx == IW'(N - 1));

   // The final B element arrives on the same edge as the commit, so the
   // committed B vector is the staging register with that element merged in.
   always_comb begin
      w_stageBMerged = r_stageB;
      w_stageBMerged[r_idx*DW +: DW] = io_bus.in_data;
   end

   // Next-state decode: walks the element index through A then B, and
   // flags an error whenever in_last disagrees with the frame position.
   always_comb begin
      w_nextState = r_state;
      w_nextIdx   = r_idx;
      w_wrA       = 1'b0;
      w_wrB       = 1'b0;
      w_commit    = 1'b0;
      w_err       = 1'b0;
      w_ackTaken  = 1'b0;
      case (r_state)
         LOAD_A: begin
            if (w_beat) begin
               if (io_bus.in_last) begin
                  w_err       = 1'b1;
                  w_nextState = LOAD_A;
                  w_nextIdx   = '0;
               end else begin
                  w_wrA = 1'b1;
                  if (w_lastElem) begin
                     w_nextState = LOAD_B;
                     w_nextIdx   = '0;
                  end else begin
                     w_nextIdx = r_idx + 1'b1;
                  end
               end
            end
         end
         LOAD_B: begin
            if (w_beat) begin
               if (w_lastElem && io_bus.in_last) begin
                  w_commit    = 1'b1;
                  w_nextState = HOLD;
                  w_nextIdx   = '0;
               end else if (w_lastElem || io_bus.in_last) begin
                  w_err       = 1'b1;
                  w_nextState = LOAD_A;
                  w_nextIdx   = '0;
               end else begin
                  w_wrB     = 1'b1;
                  w_nextIdx = r_idx + 1'b1;
               end
            end
         end
         HOLD: begin
            if (io_bus.vec_ack) begin
               w_ackTaken  = 1'b1;
               w_nextState = LOAD_A;
               w_nextIdx   = '0;
            end
         end
         default: begin
            w_nextState = LOAD_A;
            w_nextIdx   = '0;
         end
      endcase
   end

   // State and element index register.
   always_ff @(posedge cp or posedge rst) begin
      if (rst) begin
         r_state <= LOAD_A;
         r_idx   <= '0;
      end else begin
         r_state <= w_nextState;
         r_idx   <= w_nextIdx;
      end
   end

   // Staging, committed vectors, error pulse and acknowledged-frame counter.
   // The committed vectors only ever load on a commit, so dropped or
   // partial frames can never leak into them.
   always_ff @(posedge cp or posedge rst) begin
      if (rst) begin
         r_stageA   <= '0;
         r_stageB   <= '0;
         r_aVec     <= '0;
         r_bVec     <= '0;
         r_frameErr <= 1'b0;
         r_frameCnt <= 8'd0;
      end else begin
         r_frameErr <= w_err;
         if (w_wrA) begin
            r_stageA[r_idx*DW +: DW] <= io_bus.in_data;
         end
         if (w_wrB || w_commit) begin
            r_stageB <= w_stageBMerged;
         end
         if (w_commit) begin
            r_aVec <= r_stageA;
            r_bVec <= w_stageBMerged;
         end
         if (w_ackTaken) begin
            r_frameCnt <= r_frameCnt + 8'd1;
         end
      end
   end

   assign io_bus.in_ready  = (r_state != HOLD);
   assign io_bus.vec_valid = (r_state == HOLD);
   assign io_bus.a_vec     = r_aVec;
   assign io_bus.b_vec     = r_bVec;
   assign io_bus.frame_err = r_frameErr;
   assign io_bus.frame_cnt = r_frameCnt;

endmodule

// File: tb/tb_mac_operand_loader.sv
// ---------------------------------------------------------------------------
// tb_mac_operand_loader
// Directed testbench for mac_operand_loader (DW=4, N=4): clean frames,
// misplaced in_last, missing in_last, stalled input during HOLD, ignored
// acknowledges, counter wrap and mid-frame reset.
// ---------------------------------------------------------------------------
module tb_mac_operand_loader;

   logic cp;
   logic rst;

   int passCount;
   int checkCount;
   int failCount;

   mac_operand_loader_if #(.DW(4), .N(4)) bus ();

   mac_operand_loader #(.DW(4), .N(4)) dut (
      .cp     (cp),
      .rst    (rst),
      .io_bus (bus)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      cp = 1'b0;
      forever #5 cp = ~cp;
   end

   // Drives one cycle of inputs, then returns 1 time unit after the
   // rising edge so outputs are sampled away from the edge.
   task automatic applyStimulus(input logic valid, input logic [3:0] data,
                                input logic last, input logic ack);
      bus.in_valid = valid;
      bus.in_data  = data;
      bus.in_last  = last;
      bus.vec_ack  = ack;
      @(posedge cp);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) begin
         passCount++;
      end else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Sends 8 beats; beat k carries frame[k*4 +: 4]; in_last only on beat lastBeat.
   task automatic sendFrame(input logic [31:0] frame, input int lastBeat);
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b1, frame[k*4 +: 4], (k == lastBeat), 1'b0);
      end
   endtask

   task automatic checkResetValues(input string prefix);
      checkOutput({prefix, "_in_ready"},  32'(bus.in_ready),  32'd1);
      checkOutput({prefix, "_vec_valid"}, 32'(bus.vec_valid), 32'd0);
      checkOutput({prefix, "_frame_err"}, 32'(bus.frame_err), 32'd0);
      checkOutput({prefix, "_frame_cnt"}, 32'(bus.frame_cnt), 32'd0);
      checkOutput({prefix, "_a_vec"},     32'(bus.a_vec),     32'h0);
      checkOutput({prefix, "_b_vec"},     32'(bus.b_vec),     32'h0);
   endtask

   // Directed sequence of scenarios.
   initial begin
      passCount    = 0;
      checkCount   = 0;
      failCount    = 0;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = 4'h0;
      bus.in_last  = 1'b0;
      bus.vec_ack  = 1'b0;

      repeat (2) @(posedge cp);
      #1;
      checkResetValues("reset");
      rst = 1'b0;

      // Clean frame 1..8.
      sendFrame(32'h87654321, 7);
      checkOutput("f1_a_vec",     32'(bus.a_vec),     32'h4321);
      checkOutput("f1_b_vec",     32'(bus.b_vec),     32'h8765);
      checkOutput("f1_vec_valid", 32'(bus.vec_valid), 32'd1);
      checkOutput("f1_in_ready",  32'(bus.in_ready),  32'd0);
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
      checkOutput("f1_hold_valid", 32'(bus.vec_valid), 32'd1);
      checkOutput("f1_hold_a_vec", 32'(bus.a_vec),     32'h4321);
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
      checkOutput("f1_ack_valid", 32'(bus.vec_valid), 32'd0);
      checkOutput("f1_ack_cnt",   32'(bus.frame_cnt), 32'd1);
      checkOutput("f1_ack_ready", 32'(bus.in_ready),  32'd1);

      // in_last on beat 3 (index 2) is an early end.
      applyStimulus(1'b1, 4'h1, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'h2, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'h3, 1'b1, 1'b0);
      checkOutput("early_err",       32'(bus.frame_err), 32'd1);
      checkOutput("early_vec_valid", 32'(bus.vec_valid), 32'd0);
      checkOutput("early_a_vec",     32'(bus.a_vec),     32'h4321);
      checkOutput("early_b_vec",     32'(bus.b_vec),     32'h8765);
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
      checkOutput("early_err_pulse", 32'(bus.frame_err), 32'd0);
      sendFrame(32'h22229999, 7);
      checkOutput("f2_a_vec", 32'(bus.a_vec), 32'h9999);
      checkOutput("f2_b_vec", 32'(bus.b_vec), 32'h2222);
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
      checkOutput("f2_ack_cnt", 32'(bus.frame_cnt), 32'd2);

      // Ack while nothing is held is ignored.
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
      checkOutput("stray_ack_cnt",   32'(bus.frame_cnt), 32'd2);
      checkOutput("stray_ack_ready", 32'(bus.in_ready),  32'd1);

      // 8 beats without in_last: dropped; next beat starts A[0].
      sendFrame(32'h11111111, -1);
      checkOutput("nolast_err",       32'(bus.frame_err), 32'd1);
      checkOutput("nolast_vec_valid", 32'(bus.vec_valid), 32'd0);
      checkOutput("nolast_a_vec",     32'(bus.a_vec),     32'h9999);
      sendFrame(32'h11118765, 7);
      checkOutput("f3_a_vec", 32'(bus.a_vec), 32'h8765);
      checkOutput("f3_b_vec", 32'(bus.b_vec), 32'h1111);

      // Stream stalls against HOLD for 5 cycles, then ack with data still valid.
      for (int c = 0; c < 5; c++) begin
         applyStimulus(1'b1, 4'h7, 1'b0, 1'b0);
      end
      checkOutput("stall_vec_valid", 32'(bus.vec_valid), 32'd1);
      checkOutput("stall_in_ready",  32'(bus.in_ready),  32'd0);
      checkOutput("stall_a_vec",     32'(bus.a_vec),     32'h8765);
      applyStimulus(1'b1, 4'h7, 1'b0, 1'b1);
      checkOutput("stall_ack_cnt",   32'(bus.frame_cnt), 32'd3);
      checkOutput("stall_ack_ready", 32'(bus.in_ready),  32'd1);
      sendFrame(32'h76543217, 7);
      checkOutput("f4_a_vec", 32'(bus.a_vec), 32'h3217);
      checkOutput("f4_b_vec", 32'(bus.b_vec), 32'h7654);
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
      checkOutput("f4_ack_cnt", 32'(bus.frame_cnt), 32'd4);

      // Reset after 5 beats abandons the frame.
      for (int k = 1; k <= 5; k++) begin
         applyStimulus(1'b1, 4'(k), 1'b0, 1'b0);
      end
      bus.in_valid = 1'b0;
      rst = 1'b1;
      #1;
      checkResetValues("midrst");
      @(posedge cp);
      #1;
      checkOutput("midrst_err_hold", 32'(bus.frame_err), 32'd0);
      rst = 1'b0;
      sendFrame(32'h87654321, 7);
      checkOutput("post_rst_a_vec",     32'(bus.a_vec),     32'h4321);
      checkOutput("post_rst_b_vec",     32'(bus.b_vec),     32'h8765);
      checkOutput("post_rst_vec_valid", 32'(bus.vec_valid), 32'd1);
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
      checkOutput("post_rst_cnt", 32'(bus.frame_cnt), 32'd1);

      // 255 more acknowledged frames wrap the counter to 0, one more gives 1.
      for (int f = 0; f < 255; f++) begin
         sendFrame(32'h13572468, 7);
         applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
      end
      checkOutput("wrap_cnt_zero", 32'(bus.frame_cnt), 32'd0);
      checkOutput("wrap_b_vec",    32'(bus.b_vec),     32'h1357);
      sendFrame(32'h13572468, 7);
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
      checkOutput("wrap_cnt_one", 32'(bus.frame_cnt), 32'd1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/mac_operand_loader.md
MAC_OPERAND_LOADER -- requirements
Module: mac_operand_loader

Interface
- REQ-001: Parameter DW, default 4, operand element width in bits.
- REQ-002: Parameter N, default 4, elements per operand vector (the A and B vectors each hold N elements).
- REQ-003: One clock; reset is asynchronous and active-high.
- REQ-004: cp  input  1  clock; all state SHALL update on the rising edge.
- REQ-005: rst  input  1  asynchronous active-high reset.
- REQ-006: in_data  input  DW  streamed operand sample.
- REQ-007: in_valid  input  1  in_data is valid this cycle.
- REQ-008: in_last  input  1  marks the final sample of a frame.
- REQ-009: in_ready  output  1  loader accepts a sample this cycle.
- REQ-010: a_vec  output  N*DW  committed A vector; element i at bits [i*DW +: DW].
- REQ-011: b_vec  output  N*DW  committed B vector; same packing as a_vec.
- REQ-012: vec_valid  output  1  a committed frame is held for the consumer.
- REQ-013: vec_ack  input  1  consumer has taken the held frame.
- REQ-014: frame_err  output  1  one-cycle pulse when a malformed frame is discarded.
- REQ-015: frame_cnt  output  8  count of acknowledged frames.

Function
- REQ-016: A beat SHALL transfer only on a rising edge where in_valid=1 and in_ready=1.
- REQ-017: The FSM SHALL have three states: LOAD_A, LOAD_B and HOLD.
  - in_ready=1 in LOAD_A and LOAD_B.
  - in_ready=0 in HOLD.
- REQ-018: A frame SHALL be exactly 2N beats:
  - beats 0..N-1 write staging A[0..N-1] in order;
  - beats N..2N-1 write staging B[0..N-1] in order.
- REQ-019: LOAD_A SHALL go to LOAD_B after its Nth beat; the element index SHALL then restart at 0.
- REQ-020: On beat 2N-1 with in_last=1, the staging vectors SHALL be copied to a_vec/b_vec and the FSM SHALL enter HOLD.
  - vec_valid=1 from the next cycle (latency 1 cycle after the final beat).
- REQ-021: a_vec/b_vec SHALL change only on a commit; partial or discarded frames SHALL never alter them.
- REQ-022: An error SHALL occur in either case:
  - in_last=1 on any beat other than 2N-1;
  - in_last=0 on beat 2N-1.
  On an error the frame SHALL be discarded, frame_err SHALL pulse for the next cycle only, and the FSM SHALL return to LOAD_A with index 0.
- REQ-023: In HOLD, vec_valid and a_vec/b_vec SHALL stay stable until vec_ack=1 is sampled.
  - Next cycle: vec_valid=0, state LOAD_A, index 0, frame_cnt incremented.
- REQ-024: vec_ack while vec_valid=0 SHALL be ignored.
- REQ-025: frame_cnt SHALL wrap from 255 to 0.
- REQ-026: in_valid gaps of any length SHALL not disturb the index or staging contents.
- REQ-027: in_valid=1 during HOLD SHALL not be consumed; that sample is accepted no earlier than the cycle after vec_ack.

Reset
- REQ-028: While rst=1, the block SHALL be forced to LOAD_A with index 0. Outputs:
  - in_ready=1
  - vec_valid=0
  - frame_err=0
  - frame_cnt=0
  - a_vec=0, b_vec=0
  - staging cleared
- REQ-029: Reset asserted mid-frame or in HOLD SHALL abandon the frame with no frame_err pulse and no frame_cnt change.

Verification
- REQ-030: Send 1,2,3,4,5,6,7,8 with in_last on the 8th beat -> one cycle later:
  - a_vec=16'h4321, b_vec=16'h8765;
  - vec_valid=1, in_ready=0;
  - after vec_ack: vec_valid=0, frame_cnt=1.
- REQ-031: Assert in_last on beat 3 -> frame_err pulses 1 cycle, a_vec/b_vec unchanged, vec_valid=0. A following clean frame 9,9,9,9,2,2,2,2 -> a_vec=16'h9999, b_vec=16'h2222.
- REQ-032: 8 beats with in_last=0 on beat 8 -> frame_err pulse, no commit, next beat is treated as A[0].
- REQ-033: Hold in_valid=1 with data 7 during HOLD for 5 cycles -> no beat accepted. Ack -> data 7 is accepted as A[0] the cycle after the ack.
- REQ-034: Apply 256 valid, acknowledged frames -> frame_cnt returns to 0.
- REQ-035: Assert rst after 5 beats -> all outputs at reset values; the next 8-beat frame commits normally.
